instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encoding, instruction size, default reset PC
// and the {pc, instr} buffer entry layout.
package mips_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Clear the sub-word offset bits so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~(32'(INSTR_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between imem and decode.
// Push and pop may occur together; flush empties it in one cycle.
module fetch_buffer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count_q;

    // NOTE: storage is reset too, so the head reads as zero while the block is in reset.
    // NOTE: sequential state uses non-blocking assignments only; blocking here would race
    // against other flops sampling the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count_q == 2'd0);
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single outstanding imem request feeding a 2-entry buffer,
// with redirect flush and a DROP state that swallows the data of a stale request.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         push, pop, held_d, issue;
    logic [1:0]   buf_count, count_d;
    logic         buf_empty;
    fetch_entry_t head_entry;
    logic [63:0]  head_data;

    fetch_buffer #(.WIDTH(64)) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({fetch_pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign head_entry = head_data;
    assign if_valid   = !buf_empty;
    assign if_pc      = head_entry.pc;
    assign if_instr   = head_entry.instr;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        count_d    = buf_count;
        held_d     = imem_req && !imem_ack;
        issue      = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
            state_d    = held_d ? DROP : FETCH;
            count_d    = 2'd0;
        end else begin
            push = imem_req && imem_ack && (state_q == FETCH);
            pop  = if_valid && if_ready;
            if (push) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
            if (state_q == DROP && imem_ack) state_d = FETCH;
            count_d = buf_count + {1'b0, push} - {1'b0, pop};
        end

        // Request is registered, so decide on next-cycle occupancy and outstanding status.
        issue = (state_d == FETCH) && !held_d && (count_d < 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            imem_req   <= held_d || issue;
            if (issue) imem_addr <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural imem with programmable latency,
// hand-computed expectations and a buffer over/underflow monitor.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [3:0]  lat;
    logic [3:0]  wait_cnt;
    int          n_checks;
    int          n_pass;
    int          violations;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    // Memory acks after `lat` wait cycles (lat=0: same cycle as the request).
    assign imem_ack   = imem_req && (wait_cnt == lat);
    assign imem_rdata = imem_ack ? word_at(imem_addr) : 32'h0BAD_0BAD;

    always @(posedge clk or posedge reset) begin
        if (reset)                       wait_cnt <= 4'd0;
        else if (imem_req && !imem_ack)  wait_cnt <= wait_cnt + 4'd1;
        else                             wait_cnt <= 4'd0;
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (dut.u_buffer.push && dut.u_buffer.count == 2'd2) violations <= violations + 1;
            if (dut.u_buffer.pop  && dut.u_buffer.count == 2'd0) violations <= violations + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready, input logic [3:0] latency);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = ready;
        lat            = latency;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   imem_req,  1'b0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", if_valid,  1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        violations = 0;
        reset      = 1'b0;

        // Zero-wait memory, decode always ready: one instruction per cycle.
        do_reset(1'b1, 4'd0);
        step();
        check("t1_first_req",  imem_req,  1'b1);
        check("t1_first_addr", imem_addr, 32'h0);
        check("t1_not_valid",  if_valid,  1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_valid", if_valid, 1'b1);
            check("t1_pc",    if_pc,    32'(4 * i));
            check("t1_instr", if_instr, word_at(32'(4 * i)));
        end

        // Decode stalled: buffer fills to two and requests stop, then drains in order.
        do_reset(1'b0, 4'd0);
        repeat (3) step();
        check("t2_count",   32'(dut.u_buffer.count), 32'd2);
        check("t2_req_off", imem_req, 1'b0);
        check("t2_pc_hold", if_pc,    32'h0);
        step();
        check("t2_still_off", imem_req, 1'b0);
        check("t2_pc_hold2",  if_pc,    32'h0);
        if_ready = 1'b1;
        step();
        check("t2_pc4", if_pc, 32'h4);
        step();
        check("t2_pc8",    if_pc,    32'h8);
        check("t2_valid8", if_valid, 1'b1);

        // Three-cycle memory, redirect during the wait: stale data must be dropped.
        do_reset(1'b1, 4'd3);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        check("t3_req_held",  imem_req,  1'b1);
        check("t3_addr_held", imem_addr, 32'h0);
        check("t3_flushed",   if_valid,  1'b0);
        step();
        check("t3_late_ack",  imem_ack,  1'b1);
        step();
        check("t3_new_addr",  imem_addr, 32'h0000_0100);
        check("t3_dropped",   if_valid,  1'b0);
        for (int i = 0; i < 10 && !if_valid; i++) step();
        check("t3_valid", if_valid, 1'b1);
        check("t3_pc",    if_pc,    32'h0000_0100);
        check("t3_instr", if_instr, word_at(32'h0000_0100));

        // Redirect in the same cycle as an ack and a pop.
        do_reset(1'b1, 4'd0);
        repeat (3) step();
        check("t4_pre_valid", if_valid, 1'b1);
        check("t4_pre_ack",   imem_ack, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check("t4_flushed", if_valid,  1'b0);
        check("t4_no_push", 32'(dut.u_buffer.count), 32'd0);
        check("t4_req",     imem_req,  1'b1);
        check("t4_addr",    imem_addr, 32'h0000_0200);
        step();
        check("t4_pc", if_pc, 32'h0000_0200);

        // Redirect to the top word (offset bits set, must be masked), then wrap to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check("t5_flushed", if_valid,  1'b0);
        check("t5_addr",    imem_addr, 32'hFFFF_FFFC);
        step();
        check("t5_pc_top",  if_pc,     32'hFFFF_FFFC);
        check("t5_instr",   if_instr,  word_at(32'hFFFF_FFFC));
        step();
        check("t5_pc_wrap", if_pc,     32'h0000_0000);
        check("t5_valid",   if_valid,  1'b1);

        // Reset while a request is outstanding and the buffer holds an entry.
        do_reset(1'b0, 4'd1);
        repeat (3) step();
        check("t6_pre_req",   imem_req,  1'b1);
        check("t6_pre_addr",  imem_addr, 32'h4);
        check("t6_pre_valid", if_valid,  1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_req",   imem_req,  1'b0);
        check("t6_addr",  imem_addr, 32'h0);
        check("t6_valid", if_valid,  1'b0);
        check("t6_instr", if_instr,  32'h0);
        check("t6_pc",    if_pc,     32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("t6_first_req",  imem_req,  1'b1);
        check("t6_first_addr", imem_addr, 32'h0);

        check("no_overflow", 32'(violations), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
